// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: half/subkey widths, rotation schedule,
// the PC2 selection table and the subkey generator state encoding.
package des_pkg;

    localparam int C_W  = 28;
    localparam int K_W  = 48;
    localparam int CD_W = 56;

    // Left-rotation amount applied before round r (index r-1).
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES bit numbers (1-based) of the CD register selected for subkey bits 1..48.
    localparam int PC2_TBL [K_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Rotate one 28-bit half by 1 or 2 places; index 0 is the leftmost DES bit.
    function automatic logic [0:C_W-1] rot_half(
        input logic [0:C_W-1] v,
        input logic           right,
        input logic           two
    );
        logic [0:C_W-1] r;
        case ({right, two})
            2'b00:   r = {v[1:C_W-1], v[0]};
            2'b01:   r = {v[2:C_W-1], v[0:1]};
            2'b10:   r = {v[C_W-1], v[0:C_W-2]};
            default: r = {v[C_W-2:C_W-1], v[0:C_W-3]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted choice 2: combinational 56-to-48 bit selection of the CD register.
module des_pc2
    import des_pkg::*;
(
    input  logic [0:CD_W-1] i_cd,
    output logic [0:K_W-1]  o_subkey
);

    for (genvar i = 0; i < K_W; i++) begin : g_bit
        assign o_subkey[i] = i_cd[PC2_TBL[i] - 1];
    end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES round-key generator: accepts C0/D0 and streams the sixteen
// subkeys in encryption (K1..K16) or decryption (K16..K1) order.
module des_subkey_gen
    import des_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cd_valid,
    output logic            cd_ready,
    input  logic [0:C_W-1]  c_in,
    input  logic [0:C_W-1]  d_in,
    input  logic            decrypt,
    output logic            subkey_valid,
    input  logic            subkey_ready,
    output logic [0:K_W-1]  subkey,
    output logic [3:0]      round_idx,
    output logic            last
);

    state_t          r_state;
    logic            r_dir;
    logic [3:0]      r_j;
    logic [0:CD_W-1] r_cd;

    logic [3:0]      w_sched_idx;
    logic            w_two;
    logic [0:C_W-1]  w_c_nxt;
    logic [0:C_W-1]  w_d_nxt;

    // Encrypt looks ahead to the shift of round j+2; decrypt undoes the shift of round 16-j.
    always_comb begin
        w_sched_idx = r_dir ? (4'd15 - r_j) : (r_j + 4'd1);
        w_two       = (SHIFT_SCHED[w_sched_idx] == 2'd2);
        w_c_nxt     = rot_half(r_cd[0:C_W-1],    r_dir, w_two);
        w_d_nxt     = rot_half(r_cd[C_W:CD_W-1], r_dir, w_two);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_j     <= '0;
            r_cd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cd_valid) begin
                        r_state <= ACTIVE;
                        r_dir   <= decrypt;
                        r_j     <= '0;
                        // Decrypt starts from K16, whose total rotation of 28 is the identity.
                        r_cd    <= decrypt ? {c_in, d_in}
                                           : {rot_half(c_in, 1'b0, 1'b0),
                                              rot_half(d_in, 1'b0, 1'b0)};
                    end
                end
                ACTIVE: begin
                    if (subkey_ready) begin
                        if (r_j == 4'd15) begin
                            r_state <= IDLE;
                        end else begin
                            r_j  <= r_j + 4'd1;
                            r_cd <= {w_c_nxt, w_d_nxt};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .i_cd     (r_cd),
        .o_subkey (subkey)
    );

    assign cd_ready     = (r_state == IDLE);
    assign subkey_valid = (r_state == ACTIVE);
    assign round_idx    = r_j;
    assign last         = (r_state == ACTIVE) && (r_j == 4'd15);

endmodule

// File: tb/tb_des_subkey_gen.sv
// Self-checking bench for des_subkey_gen against a cumulative-shift key-schedule model.
module tb_des_subkey_gen;

    localparam int SH  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        lst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cd_valid;
    logic        cd_ready;
    logic [27:0] c_in;
    logic [27:0] d_in;
    logic        decrypt;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        last;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic stall_mode = 1'b0;
    exp_t q[$];

    des_subkey_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cd_valid     (cd_valid),
        .cd_ready     (cd_ready),
        .c_in         (c_in),
        .d_in         (d_in),
        .decrypt      (decrypt),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .last         (last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Left-rotate a 28-bit half (MSB = DES bit 1) by n places.
    function automatic logic [27:0] rotl(input logic [27:0] v, input int n);
        logic [55:0] t;
        t = {v, v};
        return t[55 - (n % 28) -: 28];
    endfunction

    // Subkey of DES round r (1..16) straight from the cumulative shift count.
    function automatic logic [47:0] model_key(input logic [27:0] c0, input logic [27:0] d0,
                                              input int r);
        int          total;
        logic [55:0] cd;
        logic [47:0] k;
        total = 0;
        for (int i = 0; i < r; i++) total += SH[i];
        cd = {rotl(c0, total), rotl(d0, total)};
        for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2[i]];
        return k;
    endfunction

    // Compare process: checks every cycle at the falling edge.
    initial begin
        logic        prev_stalled;
        logic [47:0] prev_key;
        logic [3:0]  prev_idx;
        logic        after_last;
        logic        exp_valid;
        exp_t        e;
        prev_stalled = 1'b0;
        prev_key     = '0;
        prev_idx     = '0;
        after_last   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_stalled = 1'b0;
                after_last   = 1'b0;
                continue;
            end
            exp_valid = (q.size() != 0);
            check("subkey_valid", 64'(subkey_valid), 64'(exp_valid));
            check("cd_ready", 64'(cd_ready), 64'(!exp_valid));
            if (after_last) check("cd_ready_after_last", 64'(cd_ready), 64'd1);
            after_last = 1'b0;
            if (subkey_valid && exp_valid) begin
                e = q[0];
                check("subkey", 64'(subkey), 64'(e.key));
                check("round_idx", 64'(round_idx), 64'(e.idx));
                check("last", 64'(last), 64'(e.lst));
                if (prev_stalled) begin
                    check("stall_hold_subkey", 64'(subkey), 64'(prev_key));
                    check("stall_hold_idx", 64'(round_idx), 64'(prev_idx));
                end
                if (subkey_ready) begin
                    void'(q.pop_front());
                    if (e.lst) after_last = 1'b1;
                end
            end
            prev_stalled = subkey_valid && !subkey_ready;
            prev_key     = subkey;
            prev_idx     = round_idx;
            if (cd_valid && cd_ready) begin
                for (int n = 0; n < 16; n++) begin
                    e.key = model_key(c_in, d_in, decrypt ? 16 - n : n + 1);
                    e.idx = 4'(n);
                    e.lst = (n == 15);
                    q.push_back(e);
                end
            end
        end
    end

    // Consumer: always ready, or randomly stalling.
    initial begin
        subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            subkey_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_key(input logic [27:0] c, input logic [27:0] d, input logic dec);
        logic got;
        got      = 1'b0;
        cd_valid = 1'b1;
        c_in     = c;
        d_in     = d;
        decrypt  = dec;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cd_valid = 1'b0;
        c_in     = 28'($urandom());
        d_in     = 28'($urandom());
        decrypt  = 1'($urandom());
    endtask

    task automatic wait_done();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cd_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("sequence_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cd_ready"}, 64'(cd_ready), 64'd1);
        check({tag, "_subkey_valid"}, 64'(subkey_valid), 64'd0);
        check({tag, "_subkey"}, 64'(subkey), 64'd0);
        check({tag, "_round_idx"}, 64'(round_idx), 64'd0);
        check({tag, "_last"}, 64'(last), 64'd0);
    endtask

    initial begin
        int cnt;
        logic hit;
        rst_n    = 1'b0;
        cd_valid = 1'b0;
        c_in     = '0;
        d_in     = '0;
        decrypt  = 1'b0;

        // Pin the model to the published DES example schedule.
        check("model_K1", 64'(model_key(28'hF0CCAAF, 28'h556678F, 1)), 64'h1B02EFFC7072);
        check("model_K16", 64'(model_key(28'hF0CCAAF, 28'h556678F, 16)), 64'hCB3D8B0E17F5);
        check("model_K2", 64'(model_key(28'hF0CCAAF, 28'h556678F, 2)), 64'h79AED9DBC9E5);
        check("model_ones", 64'(model_key(28'hFFFFFFF, 28'hFFFFFFF, 7)), 64'hFFFFFFFFFFFF);

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known encrypt then decrypt sequences, consumer always ready.
        send_key(28'hF0CCAAF, 28'h556678F, 1'b0);
        @(negedge clk);
        check("enc_first_literal", 64'(subkey), 64'h1B02EFFC7072);
        wait_done();
        send_key(28'hF0CCAAF, 28'h556678F, 1'b1);
        @(negedge clk);
        check("dec_first_literal", 64'(subkey), 64'hCB3D8B0E17F5);
        wait_done();

        send_key(28'hFFFFFFF, 28'hFFFFFFF, 1'b0);
        wait_done();
        send_key(28'hFFFFFFF, 28'hFFFFFFF, 1'b1);
        wait_done();

        // Random keys with consumer stalls; one cd_valid pulse during ACTIVE.
        stall_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_key(28'($urandom()), 28'($urandom()), 1'($urandom()));
            if (k == 2) begin
                repeat (3) @(posedge clk);
                #1;
                cd_valid = 1'b1;
                @(posedge clk);
                #1;
                cd_valid = 1'b0;
            end
            wait_done();
        end
        stall_mode = 1'b0;

        // Back-to-back keys with cd_valid held high and the data changing mid-sequence.
        cd_valid = 1'b1;
        c_in     = 28'($urandom());
        d_in     = 28'($urandom());
        decrypt  = 1'b0;
        for (int i = 0; i < 100 && !cd_ready; i++) @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        c_in    = 28'($urandom());
        d_in    = 28'($urandom());
        decrypt = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cd_ready) break;
            cnt++;
        end
        check("b2b_busy_cycles", 64'(cnt), 64'd16);
        @(posedge clk);
        #1;
        cd_valid = 1'b0;
        wait_done();

        // Asynchronous reset at output index 7.
        send_key(28'($urandom()), 28'($urandom()), 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (subkey_valid && round_idx == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_idx7", 64'(hit), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_idle", 64'(subkey_valid), 64'd0);

        stall_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_key(28'($urandom()), 28'($urandom()), 1'($urandom()));
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
